// File: rtl/pipelined_adder.sv
// pipelined_adder
//   Multi-stage adder/subtractor. The WIDTH-bit add is split into STAGES
//   equal slices (LSB slice first); each stage resolves one slice with
//   4-bit carry-lookahead groups and registers the carry for the next stage.
//   The last stage register is the output register.
//
//   Optional feature: define PIPELINED_ADDER_SAT_EN to add port in_sat. A beat
//   carrying in_sat=1 whose result overflows (signed) returns a saturated
//   out_sum. out_cout/out_ovf always describe the unsaturated result.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat offered
//   in_ready   pipeline can take a beat this cycle
//   in_a/in_b  operands (WIDTH)
//   in_sub     0: a+b+cin  1: a+~b+1 (cin ignored)
//   in_cin     carry-in for add mode
//   in_sat     saturate on overflow (PIPELINED_ADDER_SAT_EN only)
//   out_valid  result beat present
//   out_ready  downstream accepts the result beat
//   out_sum    result (WIDTH)
//   out_cout   carry out of the MSB (borrow = ~out_cout when subtracting)
//   out_ovf    signed two's-complement overflow
//
// Handshake: a beat moves on a rising edge when valid && ready on that side.
// The whole pipeline advances together on enable = !out_valid || out_ready,
// so in_ready is that same enable; with enable low everything holds.
// Empty stages carry valid=0 and move like any other beat (no collapsing).

module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
`ifdef PIPELINED_ADDER_SAT_EN
  input  logic             in_sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int SLICE  = WIDTH / STAGES;
  localparam int GROUPS = SLICE / 4;
  localparam int LAST   = STAGES - 1;

  // Ripple of 4-bit lookahead groups across one slice; returns {cout, sum}.
  function automatic logic [SLICE:0] add_slice(
    input logic [SLICE-1:0] x,
    input logic [SLICE-1:0] y,
    input logic             cin
  );
    logic [SLICE-1:0] s;
    logic             c;
    logic [3:0]       g;
    logic [3:0]       p;
    logic [4:0]       cc;
    s = '0;
    c = cin;
    for (int j = 0; j < GROUPS; j++) begin
      g = x[j*4 +: 4] & y[j*4 +: 4];
      p = x[j*4 +: 4] ^ y[j*4 +: 4];
      cc[0] = c;
      cc[1] = g[0] | (p[0] & c);
      cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
      cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & c);
      cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c);
      s[j*4 +: 4] = p ^ cc[3:0];
      c = cc[4];
    end
    return {c, s};
  endfunction

  // Stage registers. a_r/bp_r carry the operands (b already conditioned for
  // subtract) so later stages see their slices; sum_r holds the resolved
  // lower slices; c_r is the carry out of the slice resolved in that stage.
  logic [STAGES-1:0] v_r;
  logic [STAGES-1:0] c_r;
  logic [WIDTH-1:0]  a_r   [STAGES];
  logic [WIDTH-1:0]  bp_r  [STAGES];
  logic [WIDTH-1:0]  sum_r [STAGES];
  logic              ovf_r;

  logic [STAGES-1:0] nxt_v;
  logic [STAGES-1:0] nxt_c;
  logic [WIDTH-1:0]  nxt_a   [STAGES];
  logic [WIDTH-1:0]  nxt_bp  [STAGES];
  logic [WIDTH-1:0]  nxt_sum [STAGES];
  logic              nxt_ovf;

`ifdef PIPELINED_ADDER_SAT_EN
  logic [STAGES-1:0] sat_r;
  logic [STAGES-1:0] nxt_sat;
`endif

  logic enable;

  assign enable    = !v_r[LAST] || out_ready;
  assign in_ready  = enable;
  assign out_valid = v_r[LAST];
  assign out_sum   = sum_r[LAST];
  assign out_cout  = c_r[LAST];
  assign out_ovf   = ovf_r;

  always_comb begin
    nxt_v   = '0;
    nxt_c   = '0;
    nxt_ovf = 1'b0;
`ifdef PIPELINED_ADDER_SAT_EN
    nxt_sat = '0;
`endif
    for (int k = 0; k < STAGES; k++) begin : stage_next
      logic [WIDTH-1:0] sa;
      logic [WIDTH-1:0] sb;
      logic [WIDTH-1:0] ss;
      logic             sc;
      logic             sv;
      logic [SLICE:0]   r;
      int               pk;
      pk = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        sa = in_a;
        sb = in_sub ? ~in_b : in_b;
        ss = '0;
        sc = in_sub ? 1'b1 : in_cin;
        sv = in_valid;
`ifdef PIPELINED_ADDER_SAT_EN
        nxt_sat[k] = in_sat;
`endif
      end else begin
        sa = a_r[pk];
        sb = bp_r[pk];
        ss = sum_r[pk];
        sc = c_r[pk];
        sv = v_r[pk];
`ifdef PIPELINED_ADDER_SAT_EN
        nxt_sat[k] = sat_r[pk];
`endif
      end
      r = add_slice(sa[k*SLICE +: SLICE], sb[k*SLICE +: SLICE], sc);
      ss[k*SLICE +: SLICE] = r[SLICE-1:0];
      nxt_a[k]   = sa;
      nxt_bp[k]  = sb;
      nxt_sum[k] = ss;
      nxt_c[k]   = r[SLICE];
      nxt_v[k]   = sv;
    end

    // Overflow is judged on the wrapped sum, before any saturation.
    nxt_ovf = (nxt_a[LAST][WIDTH-1] == nxt_bp[LAST][WIDTH-1]) &&
              (nxt_sum[LAST][WIDTH-1] != nxt_a[LAST][WIDTH-1]);

`ifdef PIPELINED_ADDER_SAT_EN
    // Both operands share a sign on overflow; a's sign picks the rail.
    if (nxt_sat[LAST] && nxt_ovf) begin
      nxt_sum[LAST] = nxt_a[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r   <= '0;
      c_r   <= '0;
      ovf_r <= 1'b0;
`ifdef PIPELINED_ADDER_SAT_EN
      sat_r <= '0;
`endif
      for (int k = 0; k < STAGES; k++) begin
        a_r[k]   <= '0;
        bp_r[k]  <= '0;
        sum_r[k] <= '0;
      end
    end else if (enable) begin
      v_r   <= nxt_v;
      c_r   <= nxt_c;
      ovf_r <= nxt_ovf;
`ifdef PIPELINED_ADDER_SAT_EN
      sat_r <= nxt_sat;
`endif
      for (int k = 0; k < STAGES; k++) begin
        a_r[k]   <= nxt_a[k];
        bp_r[k]  <= nxt_bp[k];
        sum_r[k] <= nxt_sum[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Testbench for pipelined_adder (WIDTH=32, STAGES=2): reset values, a table
// of hand-computed vectors applied one at a time with latency check, a
// back-to-back stream, a backpressure stall and a mid-flight reset.

module tb_pipelined_adder;

  localparam int W = 32;
  localparam int S = 2;
  localparam int NV = 12;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic         sat;
    logic [W-1:0] sum;
    logic [W-1:0] sum_sat;
    logic         cout;
    logic         ovf;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_sub = 1'b0;
  logic         in_cin = 1'b0;
`ifdef PIPELINED_ADDER_SAT_EN
  logic         in_sat = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_sub   (in_sub),
    .in_cin   (in_cin),
`ifdef PIPELINED_ADDER_SAT_EN
    .in_sat   (in_sat),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf)
  );

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "bench timeout");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  vec_t vt[NV];
  logic [W+1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_sum(input vec_t v);
`ifdef PIPELINED_ADDER_SAT_EN
    return v.sat ? v.sum_sat : v.sum;
`else
    return v.sum;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_vec(input vec_t v);
    in_a   = v.a;
    in_b   = v.b;
    in_sub = v.sub;
    in_cin = v.cin;
`ifdef PIPELINED_ADDER_SAT_EN
    in_sat = v.sat;
`endif
  endtask

  // One beat through an empty pipe; checks latency and result fields.
  task automatic single(input int idx);
    logic got;
    int   lat;
    got = 1'b0;
    lat = 0;
    @(negedge clk);
    out_ready = 1'b1;
    drive_vec(vt[idx]);
    in_valid = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat++;
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    check($sformatf("vec%0d_valid", idx), got, 1);
    if (got) begin
      check($sformatf("vec%0d_latency", idx), lat, S);
      check($sformatf("vec%0d_sum", idx), out_sum, exp_sum(vt[idx]));
      check($sformatf("vec%0d_cout", idx), out_cout, vt[idx].cout);
      check($sformatf("vec%0d_ovf", idx), out_ovf, vt[idx].ovf);
    end
  endtask

  // Streams n table beats; out_ready is low for loop cycles stall_lo..stall_hi.
  task automatic run_stream(input string tag, input int n, input int stall_lo,
                            input int stall_hi, output int first_out,
                            output int last_out, output int got_n);
    int idx;
    logic [W+1:0] e;
    idx = 0;
    first_out = -1;
    last_out = -1;
    got_n = 0;
    for (int i = 0; i < 300 && got_n < n; i++) begin
      @(negedge clk);
      out_ready = !(i >= stall_lo && i <= stall_hi);
      if (idx < n) begin
        drive_vec(vt[idx % NV]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check({tag, "_unexpected_beat"}, 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("%s_beat%0d", tag, got_n), {out_sum, out_cout, out_ovf}, e);
        end
        if (first_out < 0) first_out = i;
        last_out = i;
        got_n++;
      end
      if (out_valid && !out_ready) check({tag, "_stall_in_ready"}, in_ready, 0);
      if (in_valid && in_ready) begin
        exp_q.push_back({exp_sum(vt[idx % NV]), vt[idx % NV].cout, vt[idx % NV].ovf});
        idx++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int first_out;
    int last_out;
    int got_n;
    int stale;

    //        a             b             sub   cin   sat   sum           sum_sat       cout  ovf
    vt[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    vt[1]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1};
    vt[2]  = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, 1'b0};
    vt[3]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1, 32'h00000000, 32'h80000000, 1'b1, 1'b1};
    vt[4]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    vt[5]  = '{32'h00000007, 32'h00000005, 1'b1, 1'b0, 1'b0, 32'h00000002, 32'h00000002, 1'b1, 1'b0};
    vt[6]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 1'b1, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1};
    vt[7]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00010000, 32'h00010000, 1'b0, 1'b0};
    vt[8]  = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, 1'b0, 32'hACF13569, 32'hACF13569, 1'b0, 1'b0};
    vt[9]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
    vt[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0};
    vt[11] = '{32'h0000FFFF, 32'h00000000, 1'b0, 1'b1, 1'b0, 32'h00010000, 32'h00010000, 1'b0, 1'b0};

    // Reset values.
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_cout", out_cout, 0);
    check("rst_out_ovf", out_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Table vectors, one at a time.
    for (int v = 0; v < NV; v++) single(v);

    // Back-to-back stream, out_ready held high.
    run_stream("stream", 3 * NV, -1, -1, first_out, last_out, got_n);
    check("stream_count", got_n, 3 * NV);
    check("stream_first_out", first_out, S);
    check("stream_rate", last_out - first_out, 3 * NV - 1);
    check("stream_queue_empty", exp_q.size(), 0);

    // Backpressure: 4 beats, out_ready low in loop cycles 3..6.
    run_stream("bp", 4, 3, 6, first_out, last_out, got_n);
    check("bp_count", got_n, 4);
    check("bp_queue_empty", exp_q.size(), 0);

    // Mid-flight reset with two beats inside the pipe.
    @(negedge clk);
    drive_vec(vt[0]);
    in_valid = 1'b1;
    @(negedge clk);
    drive_vec(vt[1]);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("mid_inflight", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_sum", out_sum, 0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("mid_rst_no_stale", stale, 0);

    // Pipe still works after the reset.
    single(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
